// File: rtl/frontend_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end (package cpu_params).
package cpu_params;

    localparam int unsigned DEFAULT_FETCH_WIDTH = 4;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h1eceb000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    // One fetch block as presented to the fetch FIFO (default width).
    typedef struct packed {
        logic [31:0]                         pc;
        logic [DEFAULT_FETCH_WIDTH*32-1:0]   inst;
        logic [DEFAULT_FETCH_WIDTH-1:0]      mask;
        logic [DEFAULT_FETCH_WIDTH-1:0]      predict_taken;
        logic [DEFAULT_FETCH_WIDTH*32-1:0]   predict_target;
    } fetch_packet_t;

    // BTB entry; the tag is the full branch PC so any index width works.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/frontend_fetch_btb.sv
// Direct-mapped branch target buffer: FETCH_WIDTH combinational read ports, one write port.
module fetch_btb
    import cpu_params::*;
#(
    parameter int unsigned FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FETCH_WIDTH*32-1:0] rd_pc,
    output logic [FETCH_WIDTH-1:0]    rd_hit,
    output logic [FETCH_WIDTH*32-1:0] rd_target,
    input  logic                     wr_en,
    input  logic [31:0]              wr_pc,
    input  logic [31:0]              wr_target
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       entries_q [BTB_ENTRIES];
    logic [IDX_W-1:0] wr_idx;

    assign wr_idx = wr_pc[2 +: IDX_W];

    // Entry storage: cleared by reset, written by resolved taken branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en) begin
            entries_q[wr_idx] <= '{valid: 1'b1, tag: wr_pc, target: wr_target};
        end
    end

    // Per-lane lookup; a write this cycle is seen by reads from the next cycle.
    always_comb begin : rd_lookup
        btb_entry_t ent;
        rd_hit    = '0;
        rd_target = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            ent = entries_q[rd_pc[i*32+2 +: IDX_W]];
            rd_hit[i]            = ent.valid && (ent.tag == rd_pc[i*32 +: 32]);
            rd_target[i*32 +: 32] = ent.target;
        end
    end

endmodule

// File: rtl/frontend_fetch.sv
// Instruction-fetch unit: block-aligned I-cache requests, one outstanding,
// stale-response discard after flush, per-lane packet masks.
// Optional BTB prediction is compiled in with `define FRONTEND_BTB_EN.
module frontend_fetch
    import cpu_params::*;
#(
    parameter int unsigned FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      backend_flush,
    input  logic [31:0]               backend_redirect_pc,
    input  logic                      bru_update_valid,
    input  logic [31:0]               bru_update_pc,
    input  logic [31:0]               bru_update_target,
    output logic                      icache_req_valid,
    input  logic                      icache_req_ready,
    output logic [31:0]               icache_req_addr,
    input  logic                      icache_resp_valid,
    input  logic [FETCH_WIDTH*32-1:0] icache_resp_data,
    output logic                      fifo_valid,
    input  logic                      fifo_ready,
    output logic [31:0]               fifo_pc,
    output logic [FETCH_WIDTH*32-1:0] fifo_inst,
    output logic [FETCH_WIDTH-1:0]    fifo_mask,
    output logic [FETCH_WIDTH-1:0]    fifo_predict_taken,
    output logic [FETCH_WIDTH*32-1:0] fifo_predict_target
);

    localparam int unsigned BLK_BYTES = FETCH_WIDTH * 4;
    localparam logic [31:0] BLK_MASK  = 32'(BLK_BYTES - 1);

    fetch_state_t              state, state_nxt;
    logic [31:0]               fetch_pc, fetch_pc_nxt;
    logic [FETCH_WIDTH*32-1:0] pkt_inst;
    logic                      pkt_load;

    logic [31:0]               blk_base;
    logic [31:0]               lane_off;
    logic [FETCH_WIDTH-1:0]    lane_hit;
    logic [FETCH_WIDTH*32-1:0] lane_tgt;
    logic [FETCH_WIDTH-1:0]    mask;
    logic [FETCH_WIDTH-1:0]    taken;
    logic [FETCH_WIDTH*32-1:0] tgt;
    logic [31:0]               next_pc;

    assign blk_base = fetch_pc & ~BLK_MASK;
    assign lane_off = (fetch_pc & BLK_MASK) >> 2;

`ifdef FRONTEND_BTB_EN
    logic [FETCH_WIDTH*32-1:0] lane_pc;

    // Word address of every lane in the current block.
    always_comb begin
        lane_pc = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_pc[i*32 +: 32] = blk_base + 32'(4 * i);
        end
    end

    fetch_btb #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (lane_pc),
        .rd_hit    (lane_hit),
        .rd_target (lane_tgt),
        .wr_en     (bru_update_valid),
        .wr_pc     (bru_update_pc),
        .wr_target (bru_update_target)
    );
`else
    logic unused_bru;

    assign lane_hit   = '0;
    assign lane_tgt   = '0;
    assign unused_bru = ^{bru_update_valid, bru_update_pc, bru_update_target, 32'(BTB_ENTRIES)};
`endif

    // Lane masks, first predicted-taken lane and the resulting next fetch PC.
    always_comb begin : lane_eval
        logic found;
        found   = 1'b0;
        mask    = '0;
        taken   = '0;
        tgt     = '0;
        next_pc = blk_base + 32'(BLK_BYTES);
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (i >= lane_off && !found) begin
                mask[i] = 1'b1;
                if (lane_hit[i]) begin
                    taken[i] = 1'b1;
                    found    = 1'b1;
                    next_pc  = lane_tgt[i*32 +: 32];
                end
            end
            tgt[i*32 +: 32] = taken[i] ? lane_tgt[i*32 +: 32] : blk_base + 32'(4 * i + 4);
        end
    end

    // Next-state and fetch-PC selection; a flush overrides the PC in every state.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pkt_load     = 1'b0;
        unique case (state)
            REQ: begin
                if (icache_req_ready) begin
                    state_nxt = backend_flush ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (icache_resp_valid) begin
                    state_nxt = backend_flush ? REQ : HOLD;
                    pkt_load  = !backend_flush;
                end else if (backend_flush) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (icache_resp_valid) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (backend_flush) begin
                    state_nxt = REQ;
                end else if (fifo_ready) begin
                    state_nxt    = REQ;
                    fetch_pc_nxt = next_pc;
                end
            end
            default: state_nxt = REQ;
        endcase
        if (backend_flush) begin
            fetch_pc_nxt = backend_redirect_pc;
        end
    end

    // Sequencer state, fetch PC and held instruction block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            pkt_inst <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (pkt_load) begin
                pkt_inst <= icache_resp_data;
            end
        end
    end

    // Outputs are zero outside their valid window, including while in reset.
    always_comb begin
        icache_req_valid    = (state == REQ) && !rst;
        icache_req_addr     = icache_req_valid ? blk_base : '0;
        fifo_valid          = (state == HOLD);
        fifo_pc             = fifo_valid ? blk_base : '0;
        fifo_inst           = fifo_valid ? pkt_inst : '0;
        fifo_mask           = fifo_valid ? mask : '0;
        fifo_predict_taken  = fifo_valid ? taken : '0;
        fifo_predict_target = fifo_valid ? tgt : '0;
    end

endmodule
